// File: rtl/serial_to_parallel.sv
// Deserializer: gathers WIDTH qualified serial bits into a word and offers it on a
// valid/ready output register, flagging framing gaps and dropped (overrun) words.
module serial_to_parallel #(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] parallel_o,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             frame_err_o,
    output logic             overrun_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] word_cnt_o
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] w_shift_nxt;
    logic [WIDTH-1:0] r_parallel;
    logic             r_out_valid;
    logic             r_frame_err;
    logic             r_overrun;
    logic [CNT_W-1:0] r_word_cnt;
    logic             w_complete;
    logic             w_gap;
    logic             w_xfer;
    logic             w_load;
    logic             w_drop;

    // LSB-first shifts right so the earliest bit ends up in bit 0.
    assign w_shift_nxt = (LSB_FIRST != 0) ? {serial_i, r_shift[WIDTH-1:1]}
                                          : {r_shift[WIDTH-2:0], serial_i};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_complete  = 1'b0;
        w_gap       = 1'b0;
        case (r_state)
            IDLE: begin
                if (valid_i) begin
                    w_cnt_nxt   = CW'(1);
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (valid_i) begin
                    if (r_cnt == CW'(WIDTH - 1)) begin
                        w_complete  = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = IDLE;
                    end else begin
                        w_cnt_nxt = r_cnt + CW'(1);
                    end
                end else begin
                    w_gap       = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_xfer = r_out_valid & out_ready_i;
    assign w_load = w_complete & (~r_out_valid | out_ready_i);
    assign w_drop = w_complete & r_out_valid & ~out_ready_i;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_shift <= '0;
        end else if (valid_i) begin
            r_shift <= w_shift_nxt;
        end
    end

    // Output register: a held word is frozen until the consumer takes it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_parallel  <= '0;
            r_out_valid <= 1'b0;
        end else if (w_load) begin
            r_parallel  <= w_shift_nxt;
            r_out_valid <= 1'b1;
        end else if (w_xfer) begin
            r_out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            r_word_cnt  <= '0;
        end else begin
            r_frame_err <= w_gap;
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (clr_i) begin
                r_overrun <= 1'b0;
            end
            if (w_xfer) begin
                r_word_cnt <= r_word_cnt + CNT_W'(1);
            end
        end
    end

    assign parallel_o  = r_parallel;
    assign out_valid_o = r_out_valid;
    assign frame_err_o = r_frame_err;
    assign overrun_o   = r_overrun;
    assign word_cnt_o  = r_word_cnt;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: LSB-first main instance plus an MSB-first
// instance sharing the same stimulus.
module tb_serial_to_parallel;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       serial_i = 1'b0;
    logic       valid_i = 1'b0;
    logic       out_ready_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [3:0] parallel_o;
    logic       out_valid_o;
    logic       frame_err_o;
    logic       overrun_o;
    logic [7:0] word_cnt_o;
    logic [3:0] m_parallel_o;
    logic       m_out_valid_o;
    logic       m_frame_err_o;
    logic       m_overrun_o;
    logic [7:0] m_word_cnt_o;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    serial_to_parallel #(.WIDTH(4), .LSB_FIRST(1), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(parallel_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .frame_err_o(frame_err_o), .overrun_o(overrun_o), .clr_i(clr_i),
        .word_cnt_o(word_cnt_o)
    );

    serial_to_parallel #(.WIDTH(4), .LSB_FIRST(0), .CNT_W(8)) dut_m (
        .clk(clk), .reset(reset), .serial_i(serial_i), .valid_i(valid_i),
        .parallel_o(m_parallel_o), .out_valid_o(m_out_valid_o), .out_ready_i(out_ready_i),
        .frame_err_o(m_frame_err_o), .overrun_o(m_overrun_o), .clr_i(clr_i),
        .word_cnt_o(m_word_cnt_o)
    );

    // Inputs change on the falling edge; outputs read there are from the last rising edge.
    task automatic drive(input logic v, input logic s);
        @(negedge clk);
        valid_i  = v;
        serial_i = s;
    endtask

    task automatic send_lsb(input logic [3:0] w);
        for (int i = 0; i < 4; i++) drive(1'b1, w[i]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0; valid_i = 1'b0; serial_i = 1'b0; clr_i = 1'b0; out_ready_i = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_total++; if (parallel_o !== 4'h0) $display("FAIL rst_par got %h exp 0", parallel_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL rst_vld got %b exp 0", out_valid_o); else n_pass++;
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL rst_ferr got %b exp 0", frame_err_o); else n_pass++;
        n_total++; if (overrun_o !== 1'b0) $display("FAIL rst_ovr got %b exp 0", overrun_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd0) $display("FAIL rst_cnt got %0d exp 0", word_cnt_o); else n_pass++;
        reset = 1'b1;
    endtask

    task automatic test_single_word();
        do_reset();
        out_ready_i = 1'b1;
        drive(1, 0); drive(1, 1); drive(1, 0); drive(1, 1);
        drive(0, 0);
        n_total++; if (out_valid_o !== 1'b1) $display("FAIL single_vld got %b exp 1", out_valid_o); else n_pass++;
        n_total++; if (parallel_o !== 4'hA) $display("FAIL single_par got %h exp A", parallel_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd0) $display("FAIL single_cnt0 got %0d exp 0", word_cnt_o); else n_pass++;
        drive(0, 0);
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL single_vld_drop got %b exp 0", out_valid_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd1) $display("FAIL single_cnt got %0d exp 1", word_cnt_o); else n_pass++;
        n_total++; if (parallel_o !== 4'hA) $display("FAIL single_par_keep got %h exp A", parallel_o); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [11:0] bits;
        logic [3:0]  words [3];
        words[0] = 4'h3; words[1] = 4'hC; words[2] = 4'hF;
        bits = {words[2], words[1], words[0]};
        do_reset();
        out_ready_i = 1'b1;
        for (int k = 0; k < 13; k++) begin
            if (k < 12) drive(1'b1, bits[k]);
            else drive(1'b0, 1'b0);
            if (k > 0 && k % 4 == 0) begin
                n_total++; if (out_valid_o !== 1'b1) $display("FAIL b2b_vld k=%0d got %b exp 1", k, out_valid_o); else n_pass++;
                n_total++; if (parallel_o !== words[k/4 - 1]) $display("FAIL b2b_par k=%0d got %h exp %h", k, parallel_o, words[k/4 - 1]); else n_pass++;
            end else begin
                n_total++; if (out_valid_o !== 1'b0) $display("FAIL b2b_idle k=%0d got %b exp 0", k, out_valid_o); else n_pass++;
            end
        end
        drive(0, 0);
        n_total++; if (word_cnt_o !== 8'd3) $display("FAIL b2b_cnt got %0d exp 3", word_cnt_o); else n_pass++;
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL b2b_ferr got %b exp 0", frame_err_o); else n_pass++;
    endtask

    task automatic test_overrun();
        do_reset();
        out_ready_i = 1'b0;
        send_lsb(4'h5);
        send_lsb(4'h9);
        drive(0, 0);
        n_total++; if (parallel_o !== 4'h5) $display("FAIL ovr_par got %h exp 5", parallel_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b1) $display("FAIL ovr_vld got %b exp 1", out_valid_o); else n_pass++;
        n_total++; if (overrun_o !== 1'b1) $display("FAIL ovr_flag got %b exp 1", overrun_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd0) $display("FAIL ovr_cnt0 got %0d exp 0", word_cnt_o); else n_pass++;
        drive(0, 0);
        out_ready_i = 1'b1;
        drive(0, 0);
        out_ready_i = 1'b0;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL ovr_xfer_vld got %b exp 0", out_valid_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd1) $display("FAIL ovr_xfer_cnt got %0d exp 1", word_cnt_o); else n_pass++;
        n_total++; if (parallel_o !== 4'h5) $display("FAIL ovr_xfer_par got %h exp 5", parallel_o); else n_pass++;
        n_total++; if (overrun_o !== 1'b1) $display("FAIL ovr_sticky got %b exp 1", overrun_o); else n_pass++;
        clr_i = 1'b1;
        drive(0, 0);
        clr_i = 1'b0;
        n_total++; if (overrun_o !== 1'b0) $display("FAIL ovr_clr got %b exp 0", overrun_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd1) $display("FAIL ovr_cnt1 got %0d exp 1", word_cnt_o); else n_pass++;
    endtask

    task automatic test_frame_err();
        do_reset();
        out_ready_i = 1'b1;
        drive(1, 1); drive(1, 0);
        drive(0, 0);
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL ferr_early got %b exp 0", frame_err_o); else n_pass++;
        drive(0, 0);
        n_total++; if (frame_err_o !== 1'b1) $display("FAIL ferr_pulse got %b exp 1", frame_err_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL ferr_vld got %b exp 0", out_valid_o); else n_pass++;
        drive(0, 0);
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL ferr_width got %b exp 0", frame_err_o); else n_pass++;
        send_lsb(4'h6);
        drive(0, 0);
        n_total++; if (out_valid_o !== 1'b1) $display("FAIL ferr_next_vld got %b exp 1", out_valid_o); else n_pass++;
        n_total++; if (parallel_o !== 4'h6) $display("FAIL ferr_next_par got %h exp 6", parallel_o); else n_pass++;
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL ferr_idle got %b exp 0", frame_err_o); else n_pass++;
    endtask

    task automatic test_xfer_complete();
        do_reset();
        out_ready_i = 1'b0;
        send_lsb(4'h3);
        drive(1, 1); drive(1, 0); drive(1, 1);
        n_total++; if (parallel_o !== 4'h3) $display("FAIL xc_hold got %h exp 3", parallel_o); else n_pass++;
        drive(1, 0);
        out_ready_i = 1'b1;
        drive(0, 0);
        out_ready_i = 1'b0;
        n_total++; if (out_valid_o !== 1'b1) $display("FAIL xc_vld got %b exp 1", out_valid_o); else n_pass++;
        n_total++; if (parallel_o !== 4'h5) $display("FAIL xc_par got %h exp 5", parallel_o); else n_pass++;
        n_total++; if (overrun_o !== 1'b0) $display("FAIL xc_ovr got %b exp 0", overrun_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd1) $display("FAIL xc_cnt got %0d exp 1", word_cnt_o); else n_pass++;
        out_ready_i = 1'b1;
        drive(0, 0);
        drive(0, 0);
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL xc_drain_vld got %b exp 0", out_valid_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd2) $display("FAIL xc_drain_cnt got %0d exp 2", word_cnt_o); else n_pass++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        out_ready_i = 1'b0;
        send_lsb(4'hA);
        drive(1, 1); drive(1, 1); drive(1, 1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++; if (parallel_o !== 4'h0) $display("FAIL rmid_par got %h exp 0", parallel_o); else n_pass++;
        n_total++; if (out_valid_o !== 1'b0) $display("FAIL rmid_vld got %b exp 0", out_valid_o); else n_pass++;
        n_total++; if (overrun_o !== 1'b0) $display("FAIL rmid_ovr got %b exp 0", overrun_o); else n_pass++;
        n_total++; if (word_cnt_o !== 8'd0) $display("FAIL rmid_cnt got %0d exp 0", word_cnt_o); else n_pass++;
        valid_i = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        out_ready_i = 1'b1;
        drive(0, 0);
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL rmid_ferr got %b exp 0", frame_err_o); else n_pass++;
        send_lsb(4'hB);
        drive(0, 0);
        n_total++; if (out_valid_o !== 1'b1) $display("FAIL rmid_new_vld got %b exp 1", out_valid_o); else n_pass++;
        n_total++; if (parallel_o !== 4'hB) $display("FAIL rmid_new_par got %h exp B", parallel_o); else n_pass++;
        n_total++; if (frame_err_o !== 1'b0) $display("FAIL rmid_new_ferr got %b exp 0", frame_err_o); else n_pass++;
    endtask

    task automatic test_msb_first();
        do_reset();
        out_ready_i = 1'b1;
        drive(1, 1); drive(1, 0); drive(1, 1); drive(1, 1);
        drive(0, 0);
        n_total++; if (m_out_valid_o !== 1'b1) $display("FAIL msb_vld got %b exp 1", m_out_valid_o); else n_pass++;
        n_total++; if (m_parallel_o !== 4'hB) $display("FAIL msb_par got %h exp B", m_parallel_o); else n_pass++;
        n_total++; if (parallel_o !== 4'hD) $display("FAIL lsb_same_bits got %h exp D", parallel_o); else n_pass++;
        drive(0, 0);
        n_total++; if (m_word_cnt_o !== 8'd1) $display("FAIL msb_cnt got %0d exp 1", m_word_cnt_o); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_xfer_complete();
        test_reset_mid();
        test_msb_first();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
